// File: rtl/me_pixel_feeder.sv
// Pixel source for the motion-estimation engine. It holds one current macroblock
// and one search window, and issues one registered row beat per en_ram strobe.
module me_pixel_feeder #(
  parameter int  MACRO_DIM  = 4,
  parameter int  SEARCH_DIM = 48,
  localparam int ADDR_W     = $clog2(SEARCH_DIM * SEARCH_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              en_ram,
  output logic              ready,
  output logic              out_valid,
  output logic              last,
  output logic [7:0]        pixel_spr_out [0:MACRO_DIM],
  output logic [7:0]        pixel_cpr_out [0:MACRO_DIM-1]
);

  localparam int S_CELLS = SEARCH_DIM * SEARCH_DIM;
  localparam int C_CELLS = MACRO_DIM * MACRO_DIM;
  localparam int C_AW    = (C_CELLS > 1) ? $clog2(C_CELLS) : 1;
  localparam int CNT_W   = $clog2(SEARCH_DIM);
  localparam int M_W     = (MACRO_DIM > 1) ? $clog2(MACRO_DIM) : 1;
  localparam int X_LAST  = SEARCH_DIM - MACRO_DIM - 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        x_q, x_d;
  logic [CNT_W-1:0]        r_q, r_d;
  logic [M_W-1:0]          rmod_q, rmod_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [MACRO_DIM:0][7:0]   spr_q, spr_d, spr_rd;
  logic [MACRO_DIM-1:0][7:0] cpr_q, cpr_d, cpr_rd;

  logic [7:0] s_mem [S_CELLS];
  logic [7:0] c_mem [C_CELLS];

  logic              wr_s_ok, wr_c_ok, last_beat;
  logic [ADDR_W-1:0] s_base;
  logic [C_AW-1:0]   c_base;

  assign wr_s_ok = (state_q == IDLE) && wr_en && wr_sel
                   && ({1'b0, wr_addr} < (ADDR_W + 1)'(S_CELLS));
  assign wr_c_ok = (state_q == IDLE) && wr_en && !wr_sel
                   && ({1'b0, wr_addr} < (ADDR_W + 1)'(C_CELLS));

  // NOTE: buffer storage has no reset on purpose; contents survive rst and a
  // reset branch would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_s_ok) s_mem[wr_addr] <= wr_data;
    if (wr_c_ok) c_mem[wr_addr[C_AW-1:0]] <= wr_data;
  end

  // Row r of the search window starting at column x, and row (r mod MACRO_DIM) of the MB.
  always_comb begin
    s_base = ADDR_W'(r_q) * ADDR_W'(SEARCH_DIM) + ADDR_W'(x_q);
    c_base = C_AW'(rmod_q) * C_AW'(MACRO_DIM);
    for (int k = 0; k <= MACRO_DIM; k++) spr_rd[k] = s_mem[s_base + ADDR_W'(k)];
    for (int k = 0; k < MACRO_DIM; k++)  cpr_rd[k] = c_mem[c_base + C_AW'(k)];
  end

  assign last_beat = (x_q == CNT_W'(X_LAST)) && (r_q == CNT_W'(SEARCH_DIM - 1));

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    rmod_d  = rmod_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    spr_d   = spr_q;
    cpr_d   = cpr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          ready_d = 1'b0;
          x_d     = '0;
          r_d     = '0;
          rmod_d  = '0;
        end
      end
      STREAM: begin
        if (en_ram) begin
          valid_d = 1'b1;
          last_d  = last_beat;
          spr_d   = spr_rd;
          cpr_d   = cpr_rd;
          if (r_q == CNT_W'(SEARCH_DIM - 1)) begin
            r_d    = '0;
            rmod_d = '0;
            x_d    = x_q + 1'b1;
          end else begin
            r_d    = r_q + 1'b1;
            rmod_d = (rmod_q == M_W'(MACRO_DIM - 1)) ? '0 : rmod_q + 1'b1;
          end
          if (last_beat) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      r_q     <= '0;
      rmod_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      spr_q   <= '0;
      cpr_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
      rmod_q  <= rmod_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      spr_q   <= spr_d;
      cpr_q   <= cpr_d;
    end
  end

  assign ready     = ready_q;
  assign out_valid = valid_q;
  assign last      = last_q;

  always_comb begin
    for (int k = 0; k <= MACRO_DIM; k++) pixel_spr_out[k] = spr_q[k];
    for (int k = 0; k < MACRO_DIM; k++)  pixel_cpr_out[k] = cpr_q[k];
  end

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Self-checking bench for me_pixel_feeder at MACRO_DIM=4, SEARCH_DIM=8: fixed-pattern
// table checks, handshake/reset corner sequences and randomized scans against a model.
module tb_me_pixel_feeder;

  localparam int M     = 4;
  localparam int S     = 8;
  localparam int AW    = 6;
  localparam int BEATS = (S - M) * S;
  localparam int SPR_W = 8 * (M + 1);
  localparam int CPR_W = 8 * M;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, en_ram = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          ready, out_valid, last;
  logic [7:0]    spr [0:M];
  logic [7:0]    cpr [0:M-1];

  int n_cmp = 0;
  int n_err = 0;

  // Reference buffers: whatever the loader was allowed to write.
  logic [7:0] s_ref [S*S];
  logic [7:0] c_ref [M*M];

  logic [SPR_W-1:0] got_spr [BEATS];
  logic [CPR_W-1:0] got_cpr [BEATS];
  logic [SPR_W-1:0] t1_spr  [BEATS];
  logic [CPR_W-1:0] t1_cpr  [BEATS];

  typedef struct {
    int               beat;
    logic [SPR_W-1:0] spr;
    logic [CPR_W-1:0] cpr;
  } vec_t;
  vec_t vecs [5];

  me_pixel_feeder #(.MACRO_DIM(M), .SEARCH_DIM(S)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .en_ram(en_ram), .ready(ready),
    .out_valid(out_valid), .last(last), .pixel_spr_out(spr), .pixel_cpr_out(cpr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SPR_W-1:0] pack_spr();
    logic [SPR_W-1:0] v = '0;
    for (int k = 0; k <= M; k++) v = {v[SPR_W-9:0], spr[k]};
    return v;
  endfunction

  function automatic logic [CPR_W-1:0] pack_cpr();
    logic [CPR_W-1:0] v = '0;
    for (int k = 0; k < M; k++) v = {v[CPR_W-9:0], cpr[k]};
    return v;
  endfunction

  // Beat b covers column x = b / S, row r = b % S.
  function automatic logic [SPR_W-1:0] exp_spr(int b);
    logic [SPR_W-1:0] v = '0;
    int x = b / S;
    int r = b % S;
    for (int k = 0; k <= M; k++) v = {v[SPR_W-9:0], s_ref[r*S + x + k]};
    return v;
  endfunction

  function automatic logic [CPR_W-1:0] exp_cpr(int b);
    logic [CPR_W-1:0] v = '0;
    int r = b % S;
    for (int k = 0; k < M; k++) v = {v[CPR_W-9:0], c_ref[(r % M)*M + k]};
    return v;
  endfunction

  task automatic do_write(input logic sel, input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load(input bit random_fill);
    logic [7:0] v;
    for (int a = 0; a < S*S; a++) begin
      v = random_fill ? 8'($urandom) : 8'(a);
      s_ref[a] = v;
      do_write(1'b1, a, v);
    end
    for (int a = 0; a < M*M; a++) begin
      v = random_fill ? 8'($urandom) : 8'(8'h80 + a);
      c_ref[a] = v;
      do_write(1'b0, a, v);
    end
  endtask

  // mode 0: en_ram held, 1: toggling, 2: random, 3: random plus writes/start mid-scan.
  task automatic run_scan(input int mode, input int abort_after);
    int               beats = 0;
    int               cyc = 0;
    bit               en;
    bit               seen_last = 0;
    logic [SPR_W-1:0] hold_spr = '0;
    logic [CPR_W-1:0] hold_cpr = '0;
    en_ram = 1'b1;
    step();
    check("idle_en_valid", 64'(out_valid), 64'(0));
    check("idle_ready", 64'(ready), 64'(1));
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ready", 64'(ready), 64'(0));
    check("start_en_valid", 64'(out_valid), 64'(0));
    while (!seen_last && beats < abort_after && cyc < 400) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      en_ram = en;
      wr_en  = 1'b0;
      start  = 1'b0;
      if (mode == 3) begin
        if (cyc == 3) begin wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 0;  wr_data = 8'hFF; end
        if (cyc == 4) begin wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 16; wr_data = 8'h11; end
        if (cyc == 5) begin wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 0;  wr_data = 8'h11; end
        start = (cyc == 7 || cyc == 9);
      end
      step();
      cyc++;
      check($sformatf("valid c%0d", cyc), 64'(out_valid), 64'(en));
      if (out_valid) begin
        got_spr[beats] = pack_spr();
        got_cpr[beats] = pack_cpr();
        check($sformatf("spr b%0d", beats), 64'(got_spr[beats]), 64'(exp_spr(beats)));
        check($sformatf("cpr b%0d", beats), 64'(got_cpr[beats]), 64'(exp_cpr(beats)));
        check($sformatf("last b%0d", beats), 64'(last), 64'(beats == BEATS - 1));
        check($sformatf("ready b%0d", beats), 64'(ready), 64'(beats == BEATS - 1));
        hold_spr  = got_spr[beats];
        hold_cpr  = got_cpr[beats];
        seen_last = last;
        beats++;
      end else begin
        check("stall_ready", 64'(ready), 64'(0));
        check("stall_last", 64'(last), 64'(0));
        if (beats > 0) begin
          check("stall_spr_hold", 64'(pack_spr()), 64'(hold_spr));
          check("stall_cpr_hold", 64'(pack_cpr()), 64'(hold_cpr));
        end
      end
    end
    wr_en  = 1'b0;
    start  = 1'b0;
    en_ram = 1'b0;
    if (abort_after >= BEATS) begin
      check("beat_count", 64'(beats), 64'(BEATS));
      en_ram = 1'b1;
      step();
      check("post_last_valid", 64'(out_valid), 64'(0));
      check("post_last_ready", 64'(ready), 64'(1));
      en_ram = 1'b0;
    end else begin
      check("abort_beats", 64'(beats), 64'(abort_after));
    end
  endtask

  initial begin
    vecs[0] = '{0,  40'h0001020304, 32'h80818283};
    vecs[1] = '{4,  40'h2021222324, 32'h80818283};
    vecs[2] = '{8,  40'h0102030405, 32'h80818283};
    vecs[3] = '{9,  40'h090A0B0C0D, 32'h84858687};
    vecs[4] = '{31, 40'h3B3C3D3E3F, 32'h8C8D8E8F};

    step();
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_last", 64'(last), 64'(0));
    check("rst_spr", 64'(pack_spr()), 64'(0));
    check("rst_cpr", 64'(pack_cpr()), 64'(0));
    rst = 1'b0;
    step();

    // Fixed pattern, continuous strobe, then the hand-derived table.
    load(1'b0);
    run_scan(0, BEATS);
    for (int b = 0; b < BEATS; b++) begin
      t1_spr[b] = got_spr[b];
      t1_cpr[b] = got_cpr[b];
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("tbl_spr b%0d", vecs[i].beat), 64'(t1_spr[vecs[i].beat]), 64'(vecs[i].spr));
      check($sformatf("tbl_cpr b%0d", vecs[i].beat), 64'(t1_cpr[vecs[i].beat]), 64'(vecs[i].cpr));
    end

    // Toggling strobe gives the same beat sequence.
    run_scan(1, BEATS);
    for (int b = 0; b < BEATS; b++) begin
      check($sformatf("toggle_spr b%0d", b), 64'(got_spr[b]), 64'(t1_spr[b]));
      check($sformatf("toggle_cpr b%0d", b), 64'(got_cpr[b]), 64'(t1_cpr[b]));
    end

    // Reset after beat 10, then rescan the retained buffers.
    run_scan(0, 11);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(ready), 64'(1));
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_last", 64'(last), 64'(0));
    check("midrst_spr", 64'(pack_spr()), 64'(0));
    check("midrst_cpr", 64'(pack_cpr()), 64'(0));
    step();
    rst = 1'b0;
    step();
    run_scan(0, BEATS);
    check("after_rst_beat0", 64'(got_spr[0]), 64'(40'h0001020304));

    // Writes and start pulses during STREAM are ignored; out-of-range cur write dropped.
    run_scan(3, BEATS);
    do_write(1'b0, 16, 8'h55);
    run_scan(0, BEATS);
    check("stream_write_s0", 64'(got_spr[0][SPR_W-1 -: 8]), 64'(8'h00));
    check("cur_unchanged", 64'(got_cpr[0]), 64'(32'h80818283));

    // Randomized contents and strobes against the model.
    load(1'b1);
    run_scan(2, BEATS);
    run_scan(3, BEATS);
    run_scan(0, BEATS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
